// File: rtl/heap_cmd_queue.sv
// heap_cmd_queue: command front-end for the heap engine.
//   Buffers push/pop commands in a DEPTH-entry FIFO and issues them to the heap
//   one at a time. The next command is not issued until heap_done comes back.
//   Pop results land in a result register with a valid flag. Illegal or
//   unserviceable commands set sticky error bits.
//
// Optional feature: define HEAP_CMD_TIMEOUT_EN to abort a WAIT that lasts
//   TIMEOUT cycles without heap_done (sets err[2]). Undefined: err[2] is 0 and
//   WAIT lasts indefinitely.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   cmd_wr/cmd_op/cmd_data  command enqueue (op 01=push, 10=pop)
//   cmd_full, cmd_count     FIFO status
//   res_rd/res_data/res_valid  pop result and its consume strobe
//   busy                    FSM active or FIFO non-empty
//   err, err_clr            sticky {timeout, overflow, illegal} and its clear
//   heap_push/heap_pop/heap_din  one-cycle strobes and operand to the heap
//   heap_dout/heap_size/heap_done  heap result, occupancy, completion pulse
module heap_cmd_queue #(
    parameter int DEPTH    = 4,
    parameter int AW       = 2,
    parameter int HEAP_MAX = 255,
    parameter int TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_wr,
    input  logic [1:0]    cmd_op,
    input  logic [7:0]    cmd_data,
    output logic          cmd_full,
    output logic [AW:0]   cmd_count,
    input  logic          res_rd,
    output logic [7:0]    res_data,
    output logic          res_valid,
    output logic          busy,
    output logic [2:0]    err,
    input  logic          err_clr,
    output logic          heap_push,
    output logic          heap_pop,
    output logic [7:0]    heap_din,
    input  logic [7:0]    heap_dout,
    input  logic [7:0]    heap_size,
    input  logic          heap_done
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;

    localparam logic [1:0] OpPush = 2'b01;
    localparam logic [1:0] OpPop  = 2'b10;

    logic [9:0]    fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [1:0]    op_q;
    logic [7:0]    data_q;
    logic [7:0]    res_data_q;
    logic          res_valid_q;
    logic [2:0]    err_q, err_d;

    logic [1:0] head_op;
    logic [7:0] head_data;
    logic       wr_accept, overflow, deq, latch, illegal_set, capture, timeout_set;

    assign head_op   = fifo_mem[rd_ptr_q][9:8];
    assign head_data = fifo_mem[rd_ptr_q][7:0];
    assign cmd_full  = (count_q == (AW+1)'(DEPTH));
    assign wr_accept = cmd_wr && !cmd_full;
    // A write while full is dropped even if a dequeue frees a slot this cycle.
    assign overflow  = cmd_wr && cmd_full;

`ifdef HEAP_CMD_TIMEOUT_EN
    logic [7:0] tmo_q;

    always_ff @(posedge clk) begin
        if (reset || state_q != StWait) tmo_q <= 8'd0;
        else                            tmo_q <= tmo_q + 8'd1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d     = state_q;
        deq         = 1'b0;
        latch       = 1'b0;
        illegal_set = 1'b0;
        capture     = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    if (head_op != OpPush && head_op != OpPop) begin
                        deq = 1'b1; illegal_set = 1'b1;
                    end else if (head_op == OpPop && heap_size == 8'd0) begin
                        deq = 1'b1; illegal_set = 1'b1;
                    end else if (head_op == OpPush && heap_size == 8'(HEAP_MAX)) begin
                        deq = 1'b1; illegal_set = 1'b1;
                    end else if (head_op == OpPop && res_valid_q) begin
                        // Hold the pop until the previous result is consumed.
                        deq = 1'b0;
                    end else begin
                        deq = 1'b1; latch = 1'b1; state_d = StIssue;
                    end
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (heap_done) begin
                    state_d = StIdle;
                    capture = (op_q == OpPop);
                end
`ifdef HEAP_CMD_TIMEOUT_EN
                else if (tmo_q == 8'(TIMEOUT - 1)) begin
                    state_d     = StIdle;
                    timeout_set = 1'b1;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (wr_accept && !deq)      count_d = count_q + 1'b1;
        else if (!wr_accept && deq) count_d = count_q - 1'b1;
    end

    // Clear first, then OR in this cycle's events so a set wins over err_clr.
    assign err_d = (err_clr ? 3'b000 : err_q) | {timeout_set, overflow, illegal_set};

    always_ff @(posedge clk) begin
        if (wr_accept) fifo_mem[wr_ptr_q] <= {cmd_op, cmd_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StIdle;
            op_q        <= 2'b00;
            data_q      <= 8'd0;
            res_data_q  <= 8'd0;
            res_valid_q <= 1'b0;
            err_q       <= 3'b000;
        end else begin
            if (wr_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (deq)       rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            state_q <= state_d;
            if (latch) begin
                op_q   <= head_op;
                data_q <= head_data;
            end
            if (capture) begin
                res_data_q  <= heap_dout;
                res_valid_q <= 1'b1;
            end else if (res_rd) begin
                res_valid_q <= 1'b0;
            end
            err_q <= err_d;
        end
    end

    assign cmd_count = count_q;
    assign res_data  = res_data_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;
    assign heap_push = (state_q == StIssue) && (op_q == OpPush);
    assign heap_pop  = (state_q == StIssue) && (op_q == OpPop);
    assign heap_din  = data_q;
    assign busy      = (state_q != StIdle) || (count_q != '0);

endmodule
